vec_exu_dispatcher: RTL
=======================

Name: vec_exu_dispatcher

Overview:
- Issue-side initiator for the vector execution unit.
- Accepts one decoded vector ALU instruction with its operands over a valid/ready handshake, then drives the execution-unit operand and control inputs and holds them stable.
- Waits a fixed latency for single-cycle ops, or for execution_done on multi-cycle ops (multiply op 3'b011, multiply-add op 3'b111).
- Captures execution_result and presents it to writeback over a second valid/ready handshake.
- Sits between the vector decode/operand-read stage and the execution unit.

Parameters:
- VLEN, `MAX_VLEN: vector operand/result width in bits.
- TIMEOUT_CYCLES, 64: maximum EXEC cycles to wait for execution_done on a multi-cycle op.
- CNT_W, 7: width of the EXEC cycle counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  dispatcher can accept.
- issue_data_1/issue_data_2/issue_data_3  in  VLEN  operands.
- issue_ctrl  in  29  packed exu_ctrl_t:
  - execution_op[3], sew_eew[7], signed_mode, mul_low, mul_high, reverse_sub_inst, Ctrl, bitwise_op[5], cmp_op[3], accum_op[3], shift_op[3].
- data_1/data_2/data_3  out  VLEN  operands to the execution unit.
- execution_op  out  3  op to the execution unit.
- sew_eew_mux_out  out  7  SEW to the execution unit.
- signed_mode, mul_low, mul_high, reverse_sub_inst, Ctrl  out  1 each  control to the execution unit.
- bitwise_op  out  5.
- cmp_op, accum_op, shift_op  out  3 each.
- execution_result  in  VLEN  result from the execution unit.
- execution_done  in  1  completion from the execution unit.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts.
- wb_result  out  VLEN  captured result.
- wb_error  out  1  timeout or illegal SEW.

Behaviour:
- Reset is synchronous and active-high; it takes priority everywhere, including mid-EXEC and mid-WB. After reset:
  - state=IDLE.
  - All EU outputs are 0, except execution_op=3'b010 (the unused code, so no EU unit is enabled).
  - wb_valid=0, wb_result=0, wb_error=0, counter=0.
  - issue_ready=1.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - issue_ready=1.
  - On issue_valid && issue_ready, register operands and issue_ctrl.
  - If sew_eew is not in {7'b0001000, 7'b0010000, 7'b0100000}: go to WB with wb_result=0, wb_error=1. No EU launch.
  - Otherwise go to EXEC and clear the counter.
- EXEC:
  - Registered operands/ctrl drive the EU outputs, held constant for the whole state. issue_ready=0.
  - Single-cycle ops (000, 001, 100, 101, 110) and unused op 010: capture execution_result at the end of the first EXEC cycle, then go to WB with wb_error=0. The instruction spends exactly 1 EXEC cycle.
  - Multi-cycle ops (011, 111):
    - execution_done is ignored in the first EXEC cycle, which masks a stale done.
    - From the second cycle on, capture execution_result when execution_done=1, then go to WB.
    - The counter increments every EXEC cycle. If the counter reaches TIMEOUT_CYCLES with no done: go to WB with wb_result=0, wb_error=1.
- WB:
  - wb_valid=1. wb_result and wb_error are held stable until wb_ready.
  - EU outputs return to their idle values (op 3'b010, data 0).
  - On wb_ready: go to IDLE. wb_valid drops next cycle. No same-cycle re-issue.
- Latency from issue handshake to wb_valid:
  - single-cycle op: 2 cycles.
  - multi-cycle op: 1 + k cycles, where k is the EXEC cycle in which done is seen (k≥2).
- If wb_ready is already high on the cycle wb_valid rises, the handshake completes that cycle.
- issue_valid while busy is ignored; the issuer holds it.

Optional Feature:
- Macro: VEC_EXU_DISPATCH_PERF_EN.
- Defined: adds outputs perf_issued (32 bit, counts accepted issues) and perf_stall (32 bit, counts WB cycles with wb_ready=0). Both are cleared by reset and wrap at 2**32.
- Undefined: these ports and counters do not exist.
- Core behaviour is identical either way.

Decomposition:
- Package vec_exu_dispatch_pkg holds:
  - exu_ctrl_t packed struct (field order as in the issue_ctrl port).
  - disp_state_e enum.
  - Op-code localparams OP_ADD=3'b000 … OP_MAC=3'b111, plus OP_IDLE=3'b010.
  - Legal SEW encodings.
  - Function is_multicycle(op).
- No sub-module; the counter and FSM are in one module.

Test Plan:
- Add op 000, SEW 7'b0100000, data_1=32'h5 lanes, data_2=32'h3 lanes, wb_ready=1 -> EU sees op 000 for exactly 1 cycle; wb_valid 2 cycles after issue; wb_result = EU result; wb_error=0.
- Multiply op 011, EU model asserts done on EXEC cycle 4, plus a stale done held high in EXEC cycle 1 -> capture on cycle 4 only; wb_valid at issue+5.
- Multiply op 011, done never asserted, TIMEOUT_CYCLES=64 -> wb_valid after 64 EXEC cycles; wb_result=0; wb_error=1; EU op returns to 3'b010.
- Illegal SEW 7'b1000000 -> no EXEC cycle (EU op stays 010); wb_error=1; wb_result=0.
- wb_ready held low 10 cycles -> wb_valid, wb_result and wb_error stable throughout; issue_ready=0; second issue_valid not accepted until 1 cycle after the handshake.
- reset asserted in EXEC cycle 3 of a multiply -> next cycle IDLE, issue_ready=1, wb_valid=0, EU op=010; a subsequent add completes normally.

Source files
------------

// File: rtl/vec_exu_dispatch_pkg.sv
// Shared types and constants for the vector execution-unit dispatcher.
// Provides a default for `MAX_VLEN when the build does not supply one.
`timescale 1ns/1ps
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

package vec_exu_dispatch_pkg;

    typedef struct packed {
        logic [2:0] execution_op;
        logic [6:0] sew_eew;
        logic       signed_mode;
        logic       mul_low;
        logic       mul_high;
        logic       reverse_sub_inst;
        logic       Ctrl;
        logic [4:0] bitwise_op;
        logic [2:0] cmp_op;
        logic [2:0] accum_op;
        logic [2:0] shift_op;
    } exu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } disp_state_e;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_IDLE  = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_LOGIC = 3'b100;
    localparam logic [2:0] OP_CMP   = 3'b101;
    localparam logic [2:0] OP_SHIFT = 3'b110;
    localparam logic [2:0] OP_MAC   = 3'b111;

    localparam logic [6:0] SEW_8  = 7'b0001000;
    localparam logic [6:0] SEW_16 = 7'b0010000;
    localparam logic [6:0] SEW_32 = 7'b0100000;

    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MAC);
    endfunction

    function automatic logic is_legal_sew(input logic [6:0] sew);
        return (sew == SEW_8) || (sew == SEW_16) || (sew == SEW_32);
    endfunction

endpackage

// File: rtl/vec_exu_dispatcher.sv
// Issues one vector ALU instruction to the execution unit and returns its result to writeback.
// Define VEC_EXU_DISPATCH_PERF_EN to add the perf_issued / perf_stall counters.
`timescale 1ns/1ps
module vec_exu_dispatcher
    import vec_exu_dispatch_pkg::*;
#(
    parameter int VLEN           = `MAX_VLEN,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic            clk,
    input  logic            reset,
`ifdef VEC_EXU_DISPATCH_PERF_EN
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall,
`endif
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [VLEN-1:0] issue_data_1,
    input  logic [VLEN-1:0] issue_data_2,
    input  logic [VLEN-1:0] issue_data_3,
    input  logic [28:0]     issue_ctrl,
    output logic [VLEN-1:0] data_1,
    output logic [VLEN-1:0] data_2,
    output logic [VLEN-1:0] data_3,
    output logic [2:0]      execution_op,
    output logic [6:0]      sew_eew_mux_out,
    output logic            signed_mode,
    output logic            mul_low,
    output logic            mul_high,
    output logic            reverse_sub_inst,
    output logic            Ctrl,
    output logic [4:0]      bitwise_op,
    output logic [2:0]      cmp_op,
    output logic [2:0]      accum_op,
    output logic [2:0]      shift_op,
    input  logic [VLEN-1:0] execution_result,
    input  logic            execution_done,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [VLEN-1:0] wb_result,
    output logic            wb_error
);

    disp_state_e     state, next_state;
    exu_ctrl_t       issue_ctrl_s, ctrl_q, eu_ctrl;
    logic [VLEN-1:0] d1_q, d2_q, d3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [VLEN-1:0] wb_result_q;
    logic            wb_error_q;
    logic            issue_fire, legal_sew, capture, timeout;

    assign issue_ctrl_s = exu_ctrl_t'(issue_ctrl);
    assign legal_sew    = is_legal_sew(issue_ctrl_s.sew_eew);
    assign issue_ready  = (state == ST_IDLE);
    assign issue_fire   = issue_valid && issue_ready;

    // A zero counter marks the first EXEC cycle, where a leftover done must be ignored.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue_fire) next_state = legal_sew ? ST_EXEC : ST_WB;
            end
            ST_EXEC: begin
                if (!is_multicycle(ctrl_q.execution_op)) begin
                    capture    = 1'b1;
                    next_state = ST_WB;
                end else if ((cnt_q != '0) && execution_done) begin
                    capture    = 1'b1;
                    next_state = ST_WB;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout    = 1'b1;
                    next_state = ST_WB;
                end
            end
            ST_WB: begin
                if (wb_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ctrl_q      <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            cnt_q       <= '0;
            wb_result_q <= '0;
            wb_error_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (issue_fire) begin
                ctrl_q <= issue_ctrl_s;
                d1_q   <= issue_data_1;
                d2_q   <= issue_data_2;
                d3_q   <= issue_data_3;
                cnt_q  <= '0;
                if (!legal_sew) begin
                    wb_result_q <= '0;
                    wb_error_q  <= 1'b1;
                end
            end
            if (state == ST_EXEC) cnt_q <= cnt_q + CNT_W'(1);
            if (capture) begin
                wb_result_q <= execution_result;
                wb_error_q  <= 1'b0;
            end
            if (timeout) begin
                wb_result_q <= '0;
                wb_error_q  <= 1'b1;
            end
        end
    end

    // Outside EXEC the EU sees the unused op code so no unit is enabled.
    always_comb begin
        eu_ctrl              = '0;
        eu_ctrl.execution_op = OP_IDLE;
        if (state == ST_EXEC) eu_ctrl = ctrl_q;
    end

    assign data_1           = (state == ST_EXEC) ? d1_q : '0;
    assign data_2           = (state == ST_EXEC) ? d2_q : '0;
    assign data_3           = (state == ST_EXEC) ? d3_q : '0;
    assign execution_op     = eu_ctrl.execution_op;
    assign sew_eew_mux_out  = eu_ctrl.sew_eew;
    assign signed_mode      = eu_ctrl.signed_mode;
    assign mul_low          = eu_ctrl.mul_low;
    assign mul_high         = eu_ctrl.mul_high;
    assign reverse_sub_inst = eu_ctrl.reverse_sub_inst;
    assign Ctrl             = eu_ctrl.Ctrl;
    assign bitwise_op       = eu_ctrl.bitwise_op;
    assign cmp_op           = eu_ctrl.cmp_op;
    assign accum_op         = eu_ctrl.accum_op;
    assign shift_op         = eu_ctrl.shift_op;

    assign wb_valid  = (state == ST_WB);
    assign wb_result = wb_result_q;
    assign wb_error  = wb_error_q;

`ifdef VEC_EXU_DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue_fire) perf_issued <= perf_issued + 32'd1;
            if ((state == ST_WB) && !wb_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
